// File: rtl/obi_ext_arb_pkg.sv
// Defaults, master indices and helpers for the external-core OBI master arbiter.
package obi_ext_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT         = 2;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;
    localparam int unsigned IDX_INSTR               = 0;
    localparam int unsigned IDX_DATA                = 1;

    typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] id_t;

    // Keeps index/pointer vectors at least one bit wide for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response structures shared across the x_heep subsystem.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of master IDs for granted transactions still awaiting rvalid.
module obi_arb_id_fifo
    import obi_ext_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_gen,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A pop in the same cycle frees a slot, so a full FIFO may still accept a push.
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rdPtr];

    always_ff @(posedge clk_gen) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 1'b1;
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_ext_master_arbiter.sv
// Round-robin arbiter sharing the external crossbar master port between the
// core's instruction and data OBI masters, with in-order response routing.
module obi_ext_master_arbiter
    import obi_pkg::*;
    import obi_ext_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = NUM_REQ_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                                   clk_gen,
    input  logic                                   rst_n,
    input  obi_req_t  [NUM_REQ-1:0]                core_req_i,
    output obi_resp_t [NUM_REQ-1:0]                core_resp_o,
    output obi_req_t                               xbar_req_o,
    input  obi_resp_t                              xbar_resp_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned ID_W  = clog2_min1(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ID_W-1:0] r_rr;
    logic [ID_W-1:0] r_sel;
    logic            r_lock;
    logic            r_err;
    logic [ID_W-1:0] w_sel;
    logic            w_found;
    logic [ID_W-1:0] w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_fwd;
    logic            w_hs;

    // A locked selection wins; otherwise scan upward from the round-robin pointer.
    always_comb begin : selectLogic
        logic [ID_W-1:0] cand;
        cand    = '0;
        w_sel   = r_sel;
        w_found = r_lock;
        if (!r_lock) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cand = ID_W'((32'(r_rr) + 32'(i)) % NUM_REQ);
                if (!w_found && core_req_i[cand].req) begin
                    w_found = 1'b1;
                    w_sel   = cand;
                end
            end
        end
    end

    // Outputs are gated by rst_n so they drop to zero as soon as reset asserts.
    assign w_pop      = rst_n & xbar_resp_i.rvalid & ~w_empty;
    assign w_fwd      = rst_n & w_found & (~w_full | w_pop);
    assign xbar_req_o = w_fwd ? core_req_i[w_sel] : '0;
    assign w_hs       = xbar_req_o.req & xbar_resp_i.gnt;

    always_comb begin
        core_resp_o = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            core_resp_o[i].gnt = w_hs && (w_sel == ID_W'(i));
            if (w_pop && (w_head == ID_W'(i))) begin
                core_resp_o[i].rvalid = 1'b1;
                core_resp_o[i].rdata  = xbar_resp_i.rdata;
            end
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W),
        .CNT_W (CNT_W)
    ) u_idFifo (
        .clk_gen (clk_gen),
        .rst_n   (rst_n),
        .i_push  (w_hs),
        .i_data  (w_sel),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_rr   <= '0;
            r_sel  <= '0;
            r_lock <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_lock <= 1'b0;
                r_rr   <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            end else if (xbar_req_o.req) begin
                r_lock <= 1'b1;
                r_sel  <= w_sel;
            end
            if (xbar_resp_i.rvalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_obi_ext_master_arbiter.sv
// Directed, table-driven bench for the external-core OBI master arbiter.
module tb_obi_ext_master_arbiter;
    import obi_pkg::*;

    localparam logic [31:0] ADDR0 = 32'h1000_0000;
    localparam logic [31:0] ADDR1 = 32'h2000_0010;
    localparam int          NVEC  = 19;

    logic                  clk_gen = 1'b0;
    logic                  rst_n;
    obi_req_t  [1:0]       coreReq;
    obi_resp_t [1:0]       coreResp;
    obi_req_t              xbarReq;
    obi_resp_t             xbarResp;
    logic [1:0]            outstanding;
    logic                  err;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [3:0]  inBits;   // {req0, req1, gnt, rvalid}
        logic [31:0] rdata;
        logic [4:0]  outBits;  // {xbar req, gnt0, gnt1, rvalid0, rvalid1}
        logic [31:0] xAddr;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  outs;
        logic        err;
    } vec_t;

    vec_t vecs[NVEC];

    obi_ext_master_arbiter #(
        .NUM_REQ         (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_gen       (clk_gen),
        .rst_n         (rst_n),
        .core_req_i    (coreReq),
        .core_resp_o   (coreResp),
        .xbar_req_o    (xbarReq),
        .xbar_resp_i   (xbarResp),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic applyStimulus(input logic r0, input logic r1, input logic g,
                                 input logic rv, input logic [31:0] rd);
        coreReq[0] = '{req: r0, we: 1'b0, be: 4'hF, addr: ADDR0, wdata: 32'h0};
        coreReq[1] = '{req: r1, we: 1'b1, be: 4'h3, addr: ADDR1, wdata: 32'hCAFE_0000};
        xbarResp   = '{gnt: g, rvalid: rv, rdata: rd};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        vecCount++;
        if (actual !== required) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    task automatic checkVec(input string tag, input vec_t v);
        checkOutput({tag, ".xreq"},  32'(xbarReq.req),        32'(v.outBits[4]));
        checkOutput({tag, ".xaddr"}, xbarReq.addr,            v.xAddr);
        checkOutput({tag, ".gnt0"},  32'(coreResp[0].gnt),    32'(v.outBits[3]));
        checkOutput({tag, ".gnt1"},  32'(coreResp[1].gnt),    32'(v.outBits[2]));
        checkOutput({tag, ".rv0"},   32'(coreResp[0].rvalid), 32'(v.outBits[1]));
        checkOutput({tag, ".rv1"},   32'(coreResp[1].rvalid), 32'(v.outBits[0]));
        checkOutput({tag, ".rd0"},   coreResp[0].rdata,       v.rd0);
        checkOutput({tag, ".rd1"},   coreResp[1].rdata,       v.rd1);
        checkOutput({tag, ".outs"},  32'(outstanding),        32'(v.outs));
        checkOutput({tag, ".err"},   32'(err),                32'(v.err));
    endtask

    task automatic setVec(input int i, input logic [3:0] inBits, input logic [31:0] rd,
                          input logic [4:0] outBits, input logic [31:0] xa,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] outs, input logic e);
        vecs[i] = '{inBits: inBits, rdata: rd, outBits: outBits, xAddr: xa,
                    rd0: d0, rd1: d1, outs: outs, err: e};
    endtask

    task automatic checkShort(input string tag, input logic xr, input logic [31:0] xa,
                              input logic g0, input logic g1, input logic v0,
                              input logic v1, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] outs, input logic e);
        vec_t v;
        v = '{inBits: 4'h0, rdata: 32'h0, outBits: {xr, g0, g1, v0, v1}, xAddr: xa,
              rd0: d0, rd1: d1, outs: outs, err: e};
        checkVec(tag, v);
    endtask

    initial begin
        // Master 1 alone with two wait states, then its response.
        setVec(0,  4'b0100, 32'h0,         5'b10000, ADDR1, 0, 0,             2'd0, 1'b0);
        setVec(1,  4'b0100, 32'h0,         5'b10000, ADDR1, 0, 0,             2'd0, 1'b0);
        setVec(2,  4'b0110, 32'h0,         5'b10100, ADDR1, 0, 0,             2'd0, 1'b0);
        setVec(3,  4'b0001, 32'hDEAD_BEEF, 5'b00001, 0,     0, 32'hDEAD_BEEF, 2'd1, 1'b0);
        // Lock on master 1 holds even though master 0 joins with rr pointing at 0.
        setVec(4,  4'b0100, 32'h0,         5'b10000, ADDR1, 0, 0,             2'd0, 1'b0);
        setVec(5,  4'b1100, 32'h0,         5'b10000, ADDR1, 0, 0,             2'd0, 1'b0);
        setVec(6,  4'b1110, 32'h0,         5'b10100, ADDR1, 0, 0,             2'd0, 1'b0);
        setVec(7,  4'b0001, 32'h55,        5'b00001, 0,     0, 32'h55,        2'd1, 1'b0);
        // Alternating grants with in-order responses 0x1 -> m0, 0x2 -> m1.
        setVec(8,  4'b1110, 32'h0,         5'b11000, ADDR0, 0, 0,             2'd0, 1'b0);
        setVec(9,  4'b1111, 32'h1,         5'b10110, ADDR1, 1, 0,             2'd1, 1'b0);
        setVec(10, 4'b1111, 32'h2,         5'b11001, ADDR0, 0, 32'h2,         2'd1, 1'b0);
        setVec(11, 4'b1110, 32'h0,         5'b10100, ADDR1, 0, 0,             2'd1, 1'b0);
        // FIFO full blocks; a pop in the same cycle lets a grant through.
        setVec(12, 4'b1110, 32'h0,         5'b00000, 0,     0, 0,             2'd2, 1'b0);
        setVec(13, 4'b1111, 32'h11,        5'b11010, ADDR0, 32'h11, 0,        2'd2, 1'b0);
        setVec(14, 4'b0001, 32'h22,        5'b00001, 0,     0, 32'h22,        2'd2, 1'b0);
        setVec(15, 4'b0001, 32'h33,        5'b00010, 0,     32'h33, 0,        2'd1, 1'b0);
        // Stray rvalid: dropped, err becomes sticky.
        setVec(16, 4'b0001, 32'h44,        5'b00000, 0,     0, 0,             2'd0, 1'b0);
        setVec(17, 4'b0000, 32'h0,         5'b00000, 0,     0, 0,             2'd0, 1'b1);
        setVec(18, 4'b0000, 32'h0,         5'b00000, 0,     0, 0,             2'd0, 1'b1);

        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
        #1;
        checkShort("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b0);
        @(negedge clk_gen);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_gen);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].inBits[3], vecs[i].inBits[2], vecs[i].inBits[1],
                          vecs[i].inBits[0], vecs[i].rdata);
            #1;
            checkVec($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk_gen);
        end

        // Build up one outstanding transaction and a locked request on master 1.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkShort("preA", 1'b1, ADDR0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b1);
        @(negedge clk_gen);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkShort("preB", 1'b1, ADDR1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'd1, 1'b1);

        // Asynchronous reset mid-cycle with requests and rvalid still active.
        #2;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
        rst_n = 1'b0;
        #1;
        checkShort("midRst", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b0);
        @(negedge clk_gen);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        checkShort("postD", 1'b1, ADDR0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b0);
        @(negedge clk_gen);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkShort("postE", 1'b1, ADDR0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b0);
        @(negedge clk_gen);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        #1;
        checkShort("postF", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h99, 0, 2'd1, 1'b0);
        @(negedge clk_gen);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h98);
        #1;
        checkShort("postG", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b0);
        @(negedge clk_gen);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkShort("postH", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
